fp32_mul_sequencer: RTL

//  Iterative IEEE-754 single-precision multiplier controller. Accepts operand pairs over a

---
 rtl/fp32_mul_pkg.sv | 20 ++
 rtl/fp_mant_shift_add.sv | 43 ++++
 rtl/fp32_mul_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fp32_mul_pkg.sv
// Shared types, field widths and operand classification for the iterative FP32 multiplier.
package fp32_mul_pkg;

  localparam int          EXP_W    = 8;
  localparam int          MAN_W    = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_t;

  // Denormals report as zero because the datapath flushes them.
  function automatic fp_class_t fp_class(input logic [30:0] x);
    if (x[30:MAN_W] == '0) return FP_ZERO;
    if (x[30:MAN_W] == '1) return (x[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
    return FP_NORMAL;
  endfunction

endpackage

// File: rtl/fp_mant_shift_add.sv
// Shift-add mantissa multiplier: retires BPC multiplier bits per step into a 48-bit accumulator.
module fp_mant_shift_add
  import fp32_mul_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        step,
  input  logic [23:0] mant_a,
  input  logic [23:0] mant_b,
  output logic [47:0] product
);

  logic [47:0] r_mcand;
  logic [23:0] r_mplier;
  logic [47:0] r_acc;
  logic [47:0] w_digit;
  logic [47:0] w_pp;

  // Multiplicand walks left while the multiplier walks right, so no per-step shifter is needed.
  assign w_digit = {{(48-BPC){1'b0}}, r_mplier[BPC-1:0]};
  assign w_pp    = r_mcand * w_digit;
  assign product = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_mcand  <= {24'd0, mant_a};
      r_mplier <= mant_b;
      r_acc    <= '0;
    end else if (step) begin
      r_acc    <= r_acc + w_pp;
      r_mcand  <= r_mcand << BPC;
      r_mplier <= r_mplier >> BPC;
    end
  end

endmodule

// File: rtl/fp32_mul_sequencer.sv
// Iterative FP32 multiplier controller: classify, sequence the shift-add multiply, normalise,
// truncate and pack. Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
module fp32_mul_sequencer
  import fp32_mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int ITERS = 24 / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic signed [9:0] BIAS_HI  = 10'(EXP_BIAS - 1);
  localparam logic signed [9:0] BIAS_LO  = 10'(EXP_BIAS);

  state_t             r_state;
  logic               r_sign;
  logic signed [9:0]  r_exp_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_result;
  logic [3:0]         r_flags;
  logic               r_out_valid;

  fp_class_t          w_cls_a;
  fp_class_t          w_cls_b;
  logic               w_accept;
  logic               w_sign;
  logic               w_is_nan;
  logic               w_is_inf;
  logic               w_is_zero;
  logic [47:0]        w_prod;
  logic signed [9:0]  w_exp_n;
  logic [MAN_W-1:0]   w_mant;
  logic               w_inexact;
  logic [31:0]        w_norm_result;
  logic [3:0]         w_norm_flags;

  assign w_cls_a   = fp_class(a[30:0]);
  assign w_cls_b   = fp_class(b[30:0]);
  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_sign    = a[31] ^ b[31];
  assign w_is_nan  = (w_cls_a == FP_NAN) || (w_cls_b == FP_NAN) ||
                     ((w_cls_a == FP_INF) && (w_cls_b == FP_ZERO)) ||
                     ((w_cls_a == FP_ZERO) && (w_cls_b == FP_INF));
  assign w_is_inf  = (w_cls_a == FP_INF) || (w_cls_b == FP_INF);
  assign w_is_zero = (w_cls_a == FP_ZERO) || (w_cls_b == FP_ZERO);

  fp_mant_shift_add #(.BPC(BITS_PER_CYCLE)) u_mant (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_accept),
    .step    (r_state == MUL),
    .mant_a  ({1'b1, a[MAN_W-1:0]}),
    .mant_b  ({1'b1, b[MAN_W-1:0]}),
    .product (w_prod)
  );

  // Normalise by at most one place; the product of two [1,2) mantissas lies in [1,4).
  always_comb begin
    w_exp_n       = '0;
    w_mant        = '0;
    w_inexact     = 1'b0;
    w_norm_result = '0;
    w_norm_flags  = '0;
    if (w_prod[47]) begin
      w_exp_n   = r_exp_sum - BIAS_HI;
      w_mant    = w_prod[46:24];
      w_inexact = |w_prod[23:0];
    end else begin
      w_exp_n   = r_exp_sum - BIAS_LO;
      w_mant    = w_prod[45:23];
      w_inexact = |w_prod[22:0];
    end
    if (w_exp_n >= 10'sd255) begin
      w_norm_result = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_norm_flags  = 4'b0101;
    end else if (w_exp_n <= 10'sd0) begin
      w_norm_result = {r_sign, 31'd0};
      w_norm_flags  = 4'b0011;
    end else begin
      w_norm_result = {r_sign, w_exp_n[EXP_W-1:0], w_mant};
      w_norm_flags  = {3'b000, w_inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_exp_sum   <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign    <= w_sign;
            r_exp_sum <= {2'b00, a[30:MAN_W]} + {2'b00, b[30:MAN_W]};
            r_cnt     <= '0;
            if (w_is_nan) begin
              r_result    <= QNAN;
              r_flags     <= 4'b1000;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_is_inf) begin
              r_result    <= {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              r_flags     <= 4'b0000;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else if (w_is_zero) begin
              r_result    <= {w_sign, 31'd0};
              r_flags     <= 4'b0000;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_state <= MUL;
            end
          end
        end
        MUL: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= NORM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        NORM: begin
          r_result    <= w_norm_result;
          r_flags     <= w_norm_flags;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign dbg_state = r_state;

endmodule
